// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
package mult_div_pkg;

  // Default operand width; HI and LO are each this wide.
  localparam int WIDTH_DEF = 32;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  // Control states of the unit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mult_div_unit_div_restore_step.sv
// One shift-subtract step of unsigned restoring division.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Shift the next dividend bit into the remainder and try subtracting the divisor.
  always_comb begin
    shifted_s = {rem_i, quot_i[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, divisor_i};
    if (!trial_s[WIDTH]) begin
      rem_o  = trial_s[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = shifted_s[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring) unit
// producing HI/LO for mfhi/mflo, one iteration per clock.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ITERS_C = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator; low WIDTH bits are the divide remainder
  logic [WIDTH-1:0] q_q, q_d;         // multiplier / quotient shift register
  logic             qm1_q, qm1_d;     // Booth q(-1) bit
  logic [WIDTH-1:0] m_q, m_d;         // multiplicand / divisor magnitude
  logic             negq_q, negq_d;   // quotient must be negated
  logic             negr_q, negr_d;   // remainder must be negated
  logic             dzp_q, dzp_d;     // divide-by-zero in flight
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH:0]   booth_acc_s;
  logic [WIDTH-1:0] booth_q_s;
  logic [WIDTH-1:0] rem_n_s;
  logic [WIDTH-1:0] quot_n_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .quot_i    (q_q),
    .divisor_i (m_q),
    .rem_o     (rem_n_s),
    .quot_o    (quot_n_s)
  );

  // Booth add/subtract followed by arithmetic right shift of {acc, Q, q-1}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum_s = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   booth_sum_s = acc_q - {m_q[WIDTH-1], m_q};
      default: booth_sum_s = acc_q;
    endcase
    booth_acc_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
    booth_q_s   = {booth_sum_s[0], q_q[WIDTH-1:1]};
  end

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    if (negq_q) begin
      quot_fix_s = ~quot_n_s + ONE_W;
    end else begin
      quot_fix_s = quot_n_s;
    end
    if (negr_q) begin
      rem_fix_s = ~rem_n_s + ONE_W;
    end else begin
      rem_fix_s = rem_n_s;
    end
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dzp_d   = dzp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          state_d = ST_MULT;
          cnt_d   = ITERS_C;
          acc_d   = '0;
          q_d     = A;
          qm1_d   = 1'b0;
          m_d     = B;
        end else if (start_div) begin
          state_d = ST_DIV;
          acc_d   = '0;
          negq_d  = A[WIDTH-1] ^ B[WIDTH-1];
          negr_d  = A[WIDTH-1];
          q_d     = A[WIDTH-1] ? (~A + ONE_W) : A;
          m_d     = B[WIDTH-1] ? (~B + ONE_W) : B;
          if (B != '0) begin
            cnt_d = ITERS_C;
            dzp_d = 1'b0;
          end else begin
            // A zero divisor spends a single cycle here so done lands one cycle after the start edge.
            cnt_d = ONE_C;
            dzp_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        acc_d = booth_acc_s;
        q_d   = booth_q_s;
        qm1_d = q_q[0];
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          hi_d    = booth_acc_s[WIDTH-1:0];
          lo_d    = booth_q_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_MULT;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q - ONE_C;
        if (dzp_q) begin
          dzp_d   = 1'b0;
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_d = {1'b0, rem_n_s};
          q_d   = quot_n_s;
          if (cnt_q == ONE_C) begin
            hi_d    = rem_fix_s;
            lo_d    = quot_fix_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_DONE: begin
        dz_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        dz_d    = 1'b0;
        dzp_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_MULT) || (state_d == ST_DIV);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dzp_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dzp_q   <= dzp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
